cache_bus_responder: RTL and testbench

- Memory-side responder for the cache's rd_*/ret_*/wr_* bus; serves line refills, dirty-line write-backs and uncached single accesses.
- Backed by one single-port synchronous SRAM (1-cycle read latency, byte write enables).
- Sits between the data cache and on-chip memory.
- One outstanding read burst plus a one-entry, 16-byte write buffer.

---
 rtl/cache_bus_responder_if.sv | 26 ++
 rtl/cache_bus_responder.sv | 180 ++++++++++++++++++
 tb/tb_cache_bus_responder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_responder_if.sv
// Cache-side request/return bus shared by the data cache and the memory responder.
interface cache_bus_responder_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/cache_bus_responder.sv
// Memory-side responder for the data cache: line refills, write-backs and
// uncached accesses served from one single-port synchronous SRAM.
module cache_bus_responder #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_bus_responder_if.slave  bus,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_t;

  rd_state_t         rd_state;
  logic [1:0]        rd_beat;
  logic              rd_line;
  logic [ADDR_W-1:0] rd_word;
  logic              ret_valid_q;
  logic              ret_last_q;

  logic              wb_valid;
  logic              wb_issue;
  logic              wb_last;
  logic              wb_line;
  logic [ADDR_W-1:0] wb_word;
  logic [3:0]        wb_strb;
  logic [127:0]      wb_data;
  logic [1:0]        wb_beat;

  logic              sram_en_q;
  logic [3:0]        sram_we_q;

  logic              rd_acc;
  logic              wr_acc;
  logic              rd_last_beat;
  logic              rd_next;
  logic [1:0]        rd_beat_n;
  logic [ADDR_W-1:0] rd_word_n;

  logic              wr_pend;
  logic              w_line;
  logic [ADDR_W-1:0] w_word;
  logic [3:0]        w_strb;
  logic [127:0]      w_data;
  logic [1:0]        w_beat;

  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                              bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

  // Writes win simultaneous requests and reads never overtake a buffered write.
  assign bus.wr_rdy = ~reset & ~wb_valid;
  assign bus.rd_rdy = ~reset & (rd_state == R_IDLE) & ~wb_valid & ~bus.wr_req;

  assign rd_acc       = bus.rd_req & bus.rd_rdy;
  assign wr_acc       = bus.wr_req & bus.wr_rdy;
  assign rd_last_beat = rd_line ? (rd_beat == 2'd3) : 1'b1;

  assign bus.ret_valid = ret_valid_q & ~reset;
  assign bus.ret_last  = ret_last_q & ~reset;
  assign bus.ret_data  = sram_rdata;
  assign sram_en       = sram_en_q & ~reset;
  assign sram_we       = sram_we_q & {4{~reset}};

  // Read beat that will own the SRAM port next cycle, if any.
  always_comb begin
    rd_next   = 1'b0;
    rd_beat_n = '0;
    rd_word_n = rd_word;
    if (rd_acc) begin
      rd_next   = 1'b1;
      rd_word_n = (bus.rd_type == TYPE_LINE) ? {bus.rd_addr[ADDR_W+1:4], 2'b00}
                                             : bus.rd_addr[ADDR_W+1:2];
    end else if ((rd_state == R_ISSUE) && !rd_last_beat) begin
      rd_next   = 1'b1;
      rd_beat_n = rd_beat + 2'd1;
    end
  end

  // Write-buffer view that includes a request being accepted this cycle, so a
  // write can start draining the very next cycle without a bubble.
  always_comb begin
    wr_pend = wr_acc | wb_issue;
    w_line  = wb_line;
    w_word  = wb_word;
    w_strb  = wb_strb;
    w_data  = wb_data;
    w_beat  = wb_beat;
    if (wr_acc) begin
      w_line = (bus.wr_type == TYPE_LINE);
      w_word = (bus.wr_type == TYPE_LINE) ? {bus.wr_addr[ADDR_W+1:4], 2'b00}
                                          : bus.wr_addr[ADDR_W+1:2];
      w_strb = bus.wr_wstrb;
      w_data = bus.wr_data;
      w_beat = '0;
    end
  end

  // Read FSM, write buffer and registered SRAM port; reads own the port while issuing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state    <= R_IDLE;
      rd_beat     <= '0;
      rd_line     <= 1'b0;
      rd_word     <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_issue    <= 1'b0;
      wb_last     <= 1'b0;
      wb_line     <= 1'b0;
      wb_word     <= '0;
      wb_strb     <= '0;
      wb_data     <= '0;
      wb_beat     <= '0;
      sram_en_q   <= 1'b0;
      sram_we_q   <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_acc) begin
            rd_state <= R_ISSUE;
            rd_beat  <= '0;
            rd_line  <= (bus.rd_type == TYPE_LINE);
            rd_word  <= rd_word_n;
          end
        end
        R_ISSUE: begin
          if (rd_last_beat) rd_state <= R_DRAIN;
          else              rd_beat  <= rd_beat_n;
        end
        R_DRAIN: rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase

      ret_valid_q <= (rd_state == R_ISSUE);
      ret_last_q  <= (rd_state == R_ISSUE) && rd_last_beat;

      if (wr_acc) begin
        wb_valid <= 1'b1;
        wb_issue <= 1'b1;
        wb_line  <= w_line;
        wb_word  <= w_word;
        wb_strb  <= w_strb;
        wb_data  <= w_data;
        wb_beat  <= '0;
      end
      // The buffer frees only after its final write has actually been on the port.
      wb_last <= 1'b0;
      if (wb_last) wb_valid <= 1'b0;

      sram_en_q <= 1'b0;
      sram_we_q <= '0;
      if (rd_next) begin
        sram_en_q <= 1'b1;
        sram_addr <= {rd_word_n[ADDR_W-1:2], rd_word_n[1:0] | rd_beat_n};
      end else if (wr_pend) begin
        sram_en_q  <= 1'b1;
        sram_we_q  <= w_line ? 4'b1111 : w_strb;
        sram_addr  <= {w_word[ADDR_W-1:2], w_word[1:0] | w_beat};
        sram_wdata <= w_data[{w_beat, 5'd0} +: 32];
        wb_beat    <= w_beat + 2'd1;
        if (w_beat == (w_line ? 2'd3 : 2'd0)) begin
          wb_issue <= 1'b0;
          wb_last  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Self-checking bench for cache_bus_responder: directed scenarios followed by
// random reads/writes checked against a word-array memory model.
module tb_cache_bus_responder;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned WORDS  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_bus_responder_if bus();

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  cache_bus_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] ref_mem  [WORDS];
  logic [31:0] sram_mem [WORDS];
  logic        loaded = 1'b0;

  function automatic logic [31:0] init_word(int unsigned i);
    if (i >= 32'h100 && i <= 32'h103) return 32'hA000_0000 + i;
    if (i == 32'h180) return 32'h1122_3344;
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Single-port synchronous SRAM, one-cycle read latency, byte writes.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_we == 4'b0000) sram_rdata <= sram_mem[sram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(logic [31:0] a);
    return (a >> 2) % WORDS;
  endfunction

  function automatic int unsigned base_of(logic [2:0] typ, logic [31:0] a);
    if (typ == 3'b100) return (word_of(a) / 4) * 4;
    return word_of(a);
  endfunction

  function automatic int unsigned beats_of(logic [2:0] typ);
    return (typ == 3'b100) ? 4 : 1;
  endfunction

  // Called #1 after the negedge of the accept cycle T of a read.
  task automatic read_check(input logic [2:0] typ, input logic [31:0] addr, input string tag);
    int unsigned n    = beats_of(typ);
    int unsigned base = base_of(typ, addr);
    logic [31:0] exp [4];
    for (int k = 0; k < 4; k++) exp[k] = ref_mem[(base + k) % WORDS];
    for (int i = 1; i <= n + 2; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b0;
      #1;
      chk({tag, "_rd_rdy"}, bus.rd_rdy, i == n + 2);
      chk({tag, "_ret_valid"}, bus.ret_valid, i >= 2 && i <= n + 1);
      if (i >= 2 && i <= n + 1) begin
        chk({tag, "_ret_data"}, bus.ret_data, exp[i-2]);
        chk({tag, "_ret_last"}, bus.ret_last, i == n + 1);
      end
      chk({tag, "_sram_en"}, sram_en, i <= n);
      if (i <= n) begin
        chk({tag, "_sram_we"}, sram_we, 4'b0000);
        chk({tag, "_sram_addr"}, sram_addr, base + i - 1);
      end
    end
  endtask

  // Called #1 after the negedge of the accept cycle T of a write.
  task automatic write_check(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [127:0] data, input string tag);
    int unsigned n    = beats_of(typ);
    int unsigned base = base_of(typ, addr);
    logic [3:0]  we   = (typ == 3'b100) ? 4'b1111 : strb;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[base + k][8*b +: 8] = data[32*k + 8*b +: 8];
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      bus.wr_req = 1'b0;
      #1;
      chk({tag, "_wr_rdy"}, bus.wr_rdy, i == n + 1);
      chk({tag, "_rd_rdy"}, bus.rd_rdy, i == n + 1);
      chk({tag, "_sram_en"}, sram_en, i <= n);
      if (i <= n) begin
        chk({tag, "_sram_we"}, sram_we, we);
        chk({tag, "_sram_addr"}, sram_addr, base + i - 1);
        chk({tag, "_sram_wdata"}, sram_wdata, data[32*(i-1) +: 32]);
      end
    end
  endtask

  task automatic do_read(input logic [2:0] typ, input logic [31:0] addr, input string tag);
    int unsigned n = 0;
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_type = typ;
    bus.rd_addr = addr;
    #1;
    while (!bus.rd_rdy && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_rd_accept"}, bus.rd_rdy, 1'b1);
    read_check(typ, addr, tag);
  endtask

  task automatic do_write(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [127:0] data, input string tag);
    int unsigned n = 0;
    @(negedge clk);
    bus.wr_req   = 1'b1;
    bus.wr_type  = typ;
    bus.wr_addr  = addr;
    bus.wr_wstrb = strb;
    bus.wr_data  = data;
    #1;
    while (!bus.wr_rdy && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_wr_accept"}, bus.wr_rdy, 1'b1);
    write_check(typ, addr, strb, data, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   types [6];
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [127:0] data;
    types = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b100};
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    bus.rd_req = 1'b0; bus.rd_type = '0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = '0; bus.wr_addr = '0;
    bus.wr_wstrb = '0; bus.wr_data = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_rd_rdy", bus.rd_rdy, 1'b0);
      chk("rst_wr_rdy", bus.wr_rdy, 1'b0);
      chk("rst_ret_valid", bus.ret_valid, 1'b0);
      chk("rst_sram_en", sram_en, 1'b0);
      chk("rst_sram_we", sram_we, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_rd_rdy", bus.rd_rdy, 1'b1);
    chk("post_rst_wr_rdy", bus.wr_rdy, 1'b1);

    // Refill, single word, write-back and uncached byte write.
    do_read(3'b100, 32'h0000_0408, "line_rd");
    do_read(3'b010, 32'h0000_040C, "word_rd");
    do_write(3'b100, 32'h0000_0800, 4'b0000,
             {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, "line_wr");
    do_read(3'b100, 32'h0000_0800, "line_rdback");
    do_write(3'b000, 32'h0000_0600, 4'b0001, 128'h5A, "byte_wr");
    do_read(3'b010, 32'h0000_0600, "byte_rdback");

    // Simultaneous requests: write first, read waits and sees the new data.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h0000_0C00;
    bus.wr_wstrb = 4'b0000; bus.wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_0C04;
    #1;
    chk("sim_rd_rdy", bus.rd_rdy, 1'b0);
    chk("sim_wr_rdy", bus.wr_rdy, 1'b1);
    write_check(3'b100, 32'h0000_0C00, 4'b0000, bus.wr_data, "sim_wr");
    read_check(3'b010, 32'h0000_0C04, "sim_rd");

    // A write accepted mid-burst drains only once the burst has issued.
    do_read(3'b000, 32'h0000_0400, "pre_arb");
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_0400;
    #1;
    chk("arb_rd_accept", bus.rd_rdy, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b0;
      bus.wr_req = (i == 1);
      if (i == 1) begin
        bus.wr_type = 3'b010; bus.wr_addr = 32'h0000_1004;
        bus.wr_wstrb = 4'b1111; bus.wr_data = {96'h0, 32'hCAFE_F00D};
      end
      #1;
      chk("arb_wr_rdy", bus.wr_rdy, i == 1 || i == 6);
      chk("arb_rd_rdy", bus.rd_rdy, i == 6);
      chk("arb_ret_valid", bus.ret_valid, i >= 2 && i <= 5);
      if (i >= 2 && i <= 5) chk("arb_ret_data", bus.ret_data, ref_mem[32'h100 + i - 2]);
      chk("arb_sram_en", sram_en, i <= 5);
      if (i <= 4) begin
        chk("arb_rd_we", sram_we, 4'b0000);
        chk("arb_rd_addr", sram_addr, 32'h100 + i - 1);
      end
      if (i == 5) begin
        chk("arb_wr_we", sram_we, 4'b1111);
        chk("arb_wr_addr", sram_addr, 32'h401);
        chk("arb_wr_wdata", sram_wdata, 32'hCAFE_F00D);
      end
    end
    ref_mem[32'h401] = 32'hCAFE_F00D;

    // Aliasing above the SRAM range and an unlisted type treated as word.
    do_read(3'b100, 32'hFFFF_0408, "alias_line");
    do_read(3'b011, 32'h0000_1007, "type011");

    // Reset in the middle of a line read.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_0408;
    #1;
    chk("mid_rst_accept", bus.rd_rdy, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b0;
      if (i == 3) reset = 1'b1;
      #1;
      if (i == 2) chk("mid_rst_beat0", bus.ret_valid, 1'b1);
      if (i >= 3) begin
        chk("mid_rst_ret_valid", bus.ret_valid, 1'b0);
        chk("mid_rst_ret_last", bus.ret_last, 1'b0);
        chk("mid_rst_sram_en", sram_en, 1'b0);
        chk("mid_rst_rd_rdy", bus.rd_rdy, 1'b0);
        chk("mid_rst_wr_rdy", bus.wr_rdy, 1'b0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("after_rst_ret_valid", bus.ret_valid, 1'b0);
      chk("after_rst_sram_en", sram_en, 1'b0);
      chk("after_rst_rd_rdy", bus.rd_rdy, 1'b1);
      chk("after_rst_wr_rdy", bus.wr_rdy, 1'b1);
    end
    do_read(3'b100, 32'h0000_0408, "fresh_rd");

    // Random mix over a small aliased window so reads hit earlier writes.
    for (int it = 0; it < 60; it++) begin
      typ  = types[$urandom_range(0, 5)];
      addr = ($urandom & 32'hF000_00FF) | 32'h0000_0400;
      if ($urandom_range(0, 1) == 1) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        do_write(typ, addr, 4'($urandom_range(0, 15)), data, "rnd_wr");
      end else begin
        do_read(typ, addr, "rnd_rd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
